// File: rtl/mult_fix_seq_if.sv
// Operand/result handshake bundle for mult_fix_seq.
// The master drives the operands and out_ready; the slave (the multiplier) returns the result.
interface mult_fix_seq_if #(
  parameter int A_W = 32,
  parameter int B_W = 32,
  parameter int O_W = 32
);
  logic           in_valid;
  logic           in_ready;
  logic [A_W-1:0] a_in;
  logic [B_W-1:0] b_in;
  logic           out_valid;
  logic           out_ready;
  logic [O_W-1:0] c_out;
  logic           ovf;

  modport master (
    output in_valid, a_in, b_in, out_ready,
    input  in_ready, out_valid, c_out, ovf
  );

  modport slave (
    input  in_valid, a_in, b_in, out_ready,
    output in_ready, out_valid, c_out, ovf
  );
endinterface

// File: rtl/mult_fix_seq.sv
// Sequential signed fixed-point multiplier: radix-2 Booth, one step per clock,
// with rounding, saturation and an overflow flag applied to the full-precision product.
module mult_fix_seq #(
  parameter int A_W   = 32,
  parameter int A_FRQ = 16,
  parameter int B_W   = 32,
  parameter int B_FRQ = 16,
  parameter int O_W   = 32,
  parameter int O_FRQ = 16,
  parameter int RND   = 1,
  parameter int SAT   = 1
) (
  input logic          clk,
  input logic          rst,
  mult_fix_seq_if.slave bus
);

  localparam int PW = A_W + B_W + 1;
  localparam int S  = A_FRQ + B_FRQ - O_FRQ;
  localparam int RS = (S > 0) ? S - 1 : 0;
  localparam int CW = (B_W > 1) ? $clog2(B_W) : 1;

  localparam logic signed [PW-1:0] RND_C = (RND != 0 && S > 0) ? (PW'(1) << RS) : '0;
  localparam logic signed [PW-1:0] MAX_V = {{(PW-O_W+1){1'b0}}, {(O_W-1){1'b1}}};
  localparam logic signed [PW-1:0] MIN_V = {{(PW-O_W+1){1'b1}}, {(O_W-1){1'b0}}};
  localparam logic [O_W-1:0] MAX_O = {1'b0, {(O_W-1){1'b1}}};
  localparam logic [O_W-1:0] MIN_O = {1'b1, {(O_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [A_W-1:0] a_q, a_d;
  logic [A_W:0]   acc_q, acc_d;
  logic [B_W-1:0] mq_q, mq_d;
  logic           bm1_q, bm1_d;
  logic [O_W-1:0] c_q, c_d;
  logic           ovf_q, ovf_d;
  logic           in_ready_q, in_ready_d;
  logic           out_valid_q, out_valid_d;

  logic [A_W:0]          mcand;
  logic [A_W:0]          sum;
  logic [PW-1:0]         shifted;
  logic signed [PW-1:0]  p_full;
  logic signed [PW-1:0]  r;
  logic                  ovf_now;
  logic [O_W-1:0]        c_now;

  // Accumulator carries one guard bit so subtracting the most negative multiplicand cannot overflow.
  always_comb begin
    mcand = {a_q[A_W-1], a_q};
    sum   = acc_q;
    case ({mq_q[0], bm1_q})
      2'b01:   sum = acc_q + mcand;
      2'b10:   sum = acc_q - mcand;
      default: sum = acc_q;
    endcase
    shifted = {sum[A_W], sum, mq_q[B_W-1:1]};
    p_full  = shifted;
    r       = (p_full + RND_C) >>> S;
    ovf_now = (r > MAX_V) || (r < MIN_V);
    c_now   = r[O_W-1:0];
    if (ovf_now && SAT != 0) begin
      c_now = r[PW-1] ? MIN_O : MAX_O;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    acc_d   = acc_q;
    mq_d    = mq_q;
    bm1_d   = bm1_q;
    c_d     = c_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_d     = bus.a_in;
          acc_d   = '0;
          mq_d    = bus.b_in;
          bm1_d   = 1'b0;
          cnt_d   = CW'(B_W - 1);
          state_d = BUSY;
        end
      end
      BUSY: begin
        acc_d = shifted[PW-1:B_W];
        mq_d  = shifted[B_W-1:0];
        bm1_d = mq_q[0];
        cnt_d = cnt_q - 1'b1;
        // Last step: the result is taken straight from this step's shifted product.
        if (cnt_q == '0) begin
          c_d     = c_now;
          ovf_d   = ovf_now;
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      a_q         <= '0;
      acc_q       <= '0;
      mq_q        <= '0;
      bm1_q       <= 1'b0;
      c_q         <= '0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      a_q         <= a_d;
      acc_q       <= acc_d;
      mq_q        <= mq_d;
      bm1_q       <= bm1_d;
      c_q         <= c_d;
      ovf_q       <= ovf_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.c_out     = c_q;
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_mult_fix_seq.sv
// Scoreboarded bench: two multipliers (round+saturate, truncate+wrap) share identical stimulus;
// expected results are queued at the accept edge and popped by per-instance monitors.
module tb_mult_fix_seq;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        tb_valid;
  logic [31:0] tb_a, tb_b;
  logic        tb_oready;

  mult_fix_seq_if #(.A_W(32), .B_W(32), .O_W(32)) bus0 ();
  mult_fix_seq_if #(.A_W(32), .B_W(32), .O_W(32)) bus1 ();

  assign bus0.in_valid  = tb_valid;
  assign bus0.a_in      = tb_a;
  assign bus0.b_in      = tb_b;
  assign bus0.out_ready = tb_oready;
  assign bus1.in_valid  = tb_valid;
  assign bus1.a_in      = tb_a;
  assign bus1.b_in      = tb_b;
  assign bus1.out_ready = tb_oready;

  mult_fix_seq #(.RND(1), .SAT(1)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  mult_fix_seq #(.RND(0), .SAT(0)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  typedef struct {
    string       name;
    logic [31:0] c;
    logic        ovf;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t e0, e1;
  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && bus0.out_valid && bus0.out_ready) begin
      if (q0.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out0: got c_out %h with no pending op", bus0.c_out);
      end else begin
        e0 = q0.pop_front();
        check({e0.name, "_c0"}, bus0.c_out, e0.c);
        check({e0.name, "_ovf0"}, {31'b0, bus0.ovf}, {31'b0, e0.ovf});
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && bus1.out_valid && bus1.out_ready) begin
      if (q1.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out1: got c_out %h with no pending op", bus1.c_out);
      end else begin
        e1 = q1.pop_front();
        check({e1.name, "_c1"}, bus1.c_out, e1.c);
        check({e1.name, "_ovf1"}, {31'b0, bus1.ovf}, {31'b0, e1.ovf});
      end
    end
  end

  // Returns just after the accept edge with in_valid dropped and operands scrambled.
  task automatic send(input string name, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] c0, input logic o0,
                      input logic [31:0] c1, input logic o1, input bit push);
    int n;
    exp_t x;
    @(posedge clk); #1;
    tb_a = a;
    tb_b = b;
    tb_valid = 1'b1;
    n = 0;
    while (!bus0.in_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL %s_accept_timeout: in_ready %b required 1", name, bus0.in_ready);
    end
    @(posedge clk);
    if (push) begin
      x.name = name; x.c = c0; x.ovf = o0; q0.push_back(x);
      x.c = c1; x.ovf = o1; q1.push_back(x);
    end
    #1;
    tb_valid = 1'b0;
    tb_a = 32'hDEAD_BEEF;
    tb_b = 32'h1234_5678;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL %s_drain_timeout: pending %0d required 0", name, q0.size() + q1.size());
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    bit ir_bad;
    tb_valid = 1'b0;
    tb_a = '0;
    tb_b = '0;
    tb_oready = 1'b1;
    rst = 1'b0;
    #1 rst = 1'b1;
    #2;
    check("rst_out_valid", {31'b0, bus0.out_valid}, 32'd0);
    check("rst_in_ready", {31'b0, bus0.in_ready}, 32'd1);
    check("rst_c_out", bus0.c_out, 32'd0);
    check("rst_ovf", {31'b0, bus0.ovf}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // 1.5 x -2.0 with latency measurement
    send("m1p5_m2", 32'h0001_8000, 32'hFFFE_0000, 32'hFFFD_0000, 1'b0, 32'hFFFD_0000, 1'b0, 1'b1);
    k = 0;
    ir_bad = 1'b0;
    while (k < 40 && !bus0.out_valid) begin
      if (bus0.in_ready) ir_bad = 1'b1;
      @(posedge clk); #1;
      k++;
    end
    check("latency", k, 32);
    check("busy_in_ready", {31'b0, ir_bad}, 32'd0);
    drain("m1p5_m2");

    send("sat_pos", 32'h7FFF_0000, 32'h0002_0000, 32'h7FFF_FFFF, 1'b1, 32'hFFFE_0000, 1'b1, 1'b1);
    drain("sat_pos");
    send("sat_neg", 32'h8000_0000, 32'h0002_0000, 32'h8000_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b1);
    drain("sat_neg");
    send("min_min", 32'h8000_0000, 32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 32'h0000_0000, 1'b1, 1'b1);
    drain("min_min");
    send("rnd_pos", 32'h0000_0001, 32'h0000_8000, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b0, 1'b1);
    drain("rnd_pos");
    send("rnd_neg", 32'hFFFF_FFFF, 32'h0000_8000, 32'h0000_0000, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b1);
    drain("rnd_neg");

    // Backpressure: hold out_ready low, pulse in_valid while busy
    tb_oready = 1'b0;
    send("bp", 32'h0002_0000, 32'h0003_0000, 32'h0006_0000, 1'b0, 32'h0006_0000, 1'b0, 1'b1);
    repeat (5) @(posedge clk);
    #1;
    tb_a = 32'h0010_0000;
    tb_b = 32'h0010_0000;
    tb_valid = 1'b1;
    @(posedge clk); #1;
    tb_valid = 1'b0;
    k = 0;
    while (k < 60 && !bus0.out_valid) begin
      @(posedge clk); #1;
      k++;
    end
    for (int i = 0; i < 5; i++) begin
      check("bp_c_hold", bus0.c_out, 32'h0006_0000);
      check("bp_ovf_hold", {31'b0, bus0.ovf}, 32'd0);
      check("bp_valid_hold", {31'b0, bus0.out_valid}, 32'd1);
      check("bp_in_ready", {31'b0, bus0.in_ready}, 32'd0);
      @(posedge clk); #1;
    end
    tb_oready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_in_ready", {31'b0, bus0.in_ready}, 32'd1);
    check("bp_release_valid", {31'b0, bus0.out_valid}, 32'd0);
    drain("bp");

    // Reset mid-operation aborts without a result
    send("abort", 32'h0005_0000, 32'h0005_0000, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    repeat (10) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort_out_valid", {31'b0, bus0.out_valid}, 32'd0);
    check("abort_c_out", bus0.c_out, 32'd0);
    check("abort_in_ready", {31'b0, bus0.in_ready}, 32'd1);
    check("abort_c_out1", bus1.c_out, 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    send("after_rst", 32'h0003_0000, 32'h0000_4000, 32'h0000_C000, 1'b0, 32'h0000_C000, 1'b0, 1'b1);
    drain("after_rst");

    repeat (50) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
